// File: rtl/ham_pkg.sv
// Shared definitions for the extended-Hamming (SECDED) decoder family.
//   ham_par_w : parity-bit count for a payload width
//   is_pow2   : true for Hamming parity positions
//   data_pos  : Hamming position (1-based) of payload bit idx
//   ham_status_e : per-word decode classification
package ham_pkg;

    typedef enum logic [1:0] {
        HAM_CLEAN,
        HAM_CORR,
        HAM_UNCORR
    } ham_status_e;

    // Smallest r with 2^r >= data_w + r + 1. Scanning downward leaves the
    // smallest satisfying r in the result.
    function automatic int ham_par_w(input int data_w);
        int r;
        r = 0;
        for (int k = 8; k >= 1; k--) begin
            if ((1 << k) >= data_w + k + 1) r = k;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Payload bits fill the non-power-of-two positions in ascending order.
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p < 128; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ham_syndrome_calc.sv
// Combinational syndrome / overall-parity generator for an extended Hamming
// codeword. Bit i of code (i < CODE_W-1) is Hamming position i+1; the top
// bit is the overall parity bit.
//   code     in  CODE_W  codeword
//   syndrome out PAR_W   XOR of positions whose index has bit k set
//   overall  out 1       XOR of every codeword bit (0 for a clean word)
module ham_syndrome_calc #(
    parameter int CODE_W = 8,
    parameter int PAR_W  = 3
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  syndrome,
    output logic              overall
);

    always_comb begin
        syndrome = '0;
        for (int p = 1; p < CODE_W; p++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (((p >> k) & 1) == 1) syndrome[k] = syndrome[k] ^ code[p-1];
            end
        end
    end

    assign overall = ^code;

endmodule

// File: rtl/ham_secded_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready streaming and
// saturating error counters.
//   clk, reset_n         clock / async active-low reset
//   in_valid/in_ready    input handshake, in_code = received codeword
//   out_valid/out_ready  output handshake
//   out_data             corrected payload (uncorrected when out_err_uncorr)
//   out_err_corr         single error fixed (incl. overall-parity bit)
//   out_err_uncorr       double error / syndrome beyond the codeword
//   out_syndrome         raw syndrome for debug
//   cnt_clr              sync clear of both counters (wins over increment)
//   cnt_corr/cnt_uncorr  saturating per-word error counts
module ham_secded_decoder
    import ham_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  CNT_W  = 16,
    localparam int PAR_W  = ham_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_corr,
    output logic              out_err_uncorr,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam int STAGES = 2;

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- Stage 1 inputs ----------------
    logic [PAR_W-1:0]  in_syn;
    logic              in_par;
    logic [DATA_W-1:0] in_data;

    ham_syndrome_calc #(
        .CODE_W (CODE_W),
        .PAR_W  (PAR_W)
    ) u_syn (
        .code     (in_code),
        .syndrome (in_syn),
        .overall  (in_par)
    );

    // Only payload bits are kept past S1: syndrome and P already carry
    // everything the parity bits have to say.
    for (genvar i = 0; i < DATA_W; i++) begin : g_in_data
        localparam int POS = data_pos(i);
        assign in_data[i] = in_code[POS-1];
    end

    // ---------------- State ----------------
    logic [STAGES:1]   vld_pipe_d, vld_pipe_q;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;
    logic [PAR_W-1:0]  s1_syn_d, s1_syn_q;
    logic              s1_par_d, s1_par_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic              out_corr_d, out_corr_q;
    logic              out_uncorr_d, out_uncorr_q;
    logic [PAR_W-1:0]  out_syn_d, out_syn_q;
    logic [CNT_W-1:0]  cnt_corr_d, cnt_corr_q;
    logic [CNT_W-1:0]  cnt_uncorr_d, cnt_uncorr_q;

    // ---------------- Stage 2 classification ----------------
    ham_status_e       status;
    logic              flip;
    logic [DATA_W-1:0] fix_data;

    always_comb begin
        status = HAM_CLEAN;
        flip   = 1'b0;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                status = HAM_CORR;            // overall-parity bit itself flipped
            end else if (int'(s1_syn_q) <= CODE_W - 1) begin
                status = HAM_CORR;
                flip   = 1'b1;
            end else begin
                status = HAM_UNCORR;          // syndrome names a position that does not exist
            end
        end else if (s1_syn_q != '0) begin
            status = HAM_UNCORR;              // even parity with nonzero syndrome: double error
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_fix
        localparam int POS = data_pos(i);
        assign fix_data[i] = s1_data_q[i] ^ (flip & (s1_syn_q == PAR_W'(POS)));
    end

    // ---------------- Pipeline advance ----------------
    always_comb begin
        vld_pipe_d   = vld_pipe_q;
        s1_data_d    = s1_data_q;
        s1_syn_d     = s1_syn_q;
        s1_par_d     = s1_par_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_syn_d    = out_syn_q;
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
            if (in_valid) begin
                s1_data_d = in_data;
                s1_syn_d  = in_syn;
                s1_par_d  = in_par;
            end
            if (vld_pipe_q[1]) begin
                out_data_d   = (status == HAM_UNCORR) ? s1_data_q : fix_data;
                out_corr_d   = (status == HAM_CORR);
                out_uncorr_d = (status == HAM_UNCORR);
                out_syn_d    = s1_syn_q;
            end
        end
    end

    // ---------------- Counters ----------------
    // Counted on the output handshake so a stalled word is counted once.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_valid && out_ready) begin
            if (out_corr_q && (cnt_corr_q != '1))     cnt_corr_d   = cnt_corr_q + 1'b1;
            if (out_uncorr_q && (cnt_uncorr_q != '1)) cnt_uncorr_d = cnt_uncorr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q   <= '0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_syn_q    <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_syn_q    <= out_syn_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_valid      = vld_pipe_q[STAGES];
    assign out_data       = out_data_q;
    assign out_err_corr   = out_corr_q;
    assign out_err_uncorr = out_uncorr_q;
    assign out_syndrome   = out_syn_q;
    assign cnt_corr       = cnt_corr_q;
    assign cnt_uncorr     = cnt_uncorr_q;

endmodule

// File: tb/tb_ham_secded_decoder.sv
// Directed bench for ham_secded_decoder: legacy (8,4) vectors, stall,
// counter saturation/clear, mid-stream reset, and single/double-error
// sweeps at payload widths 8, 32 and 64.
module tb_ham_secded_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, out_ready, cnt_clr;
    logic [7:0] in_code;

    // DATA_W=4, CNT_W=16
    logic        in_ready, out_valid, out_err_corr, out_err_uncorr;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic [15:0] cnt_corr, cnt_uncorr;

    // DATA_W=4, CNT_W=2, same input stream
    logic       s_ir, s_ov, s_c, s_u;
    logic [3:0] s_d;
    logic [2:0] s_s;
    logic [1:0] s_cc, s_cu;

    // wide instances
    logic [2:0]  w_valid;
    logic [71:0] w_code;
    logic        w_ready, w_clr;
    logic        w8_ir, w8_ov, w8_c, w8_u;
    logic [7:0]  w8_d;
    logic [3:0]  w8_s;
    logic [15:0] w8_cc, w8_cu;
    logic        w32_ir, w32_ov, w32_c, w32_u;
    logic [31:0] w32_d;
    logic [5:0]  w32_s;
    logic [15:0] w32_cc, w32_cu;
    logic        w64_ir, w64_ov, w64_c, w64_u;
    logic [63:0] w64_d;
    logic [6:0]  w64_s;
    logic [15:0] w64_cc, w64_cu;

    ham_secded_decoder #(.DATA_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err_corr(out_err_corr), .out_err_uncorr(out_err_uncorr),
        .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .cnt_corr(cnt_corr),
        .cnt_uncorr(cnt_uncorr));

    ham_secded_decoder #(.DATA_W(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(s_ir),
        .in_code(in_code), .out_valid(s_ov), .out_ready(out_ready),
        .out_data(s_d), .out_err_corr(s_c), .out_err_uncorr(s_u),
        .out_syndrome(s_s), .cnt_clr(cnt_clr), .cnt_corr(s_cc), .cnt_uncorr(s_cu));

    ham_secded_decoder #(.DATA_W(8), .CNT_W(16)) u_w8 (
        .clk(clk), .reset_n(rst_n), .in_valid(w_valid[0]), .in_ready(w8_ir),
        .in_code(w_code[12:0]), .out_valid(w8_ov), .out_ready(w_ready),
        .out_data(w8_d), .out_err_corr(w8_c), .out_err_uncorr(w8_u),
        .out_syndrome(w8_s), .cnt_clr(w_clr), .cnt_corr(w8_cc), .cnt_uncorr(w8_cu));

    ham_secded_decoder #(.DATA_W(32), .CNT_W(16)) u_w32 (
        .clk(clk), .reset_n(rst_n), .in_valid(w_valid[1]), .in_ready(w32_ir),
        .in_code(w_code[38:0]), .out_valid(w32_ov), .out_ready(w_ready),
        .out_data(w32_d), .out_err_corr(w32_c), .out_err_uncorr(w32_u),
        .out_syndrome(w32_s), .cnt_clr(w_clr), .cnt_corr(w32_cc), .cnt_uncorr(w32_cu));

    ham_secded_decoder #(.DATA_W(64), .CNT_W(16)) u_w64 (
        .clk(clk), .reset_n(rst_n), .in_valid(w_valid[2]), .in_ready(w64_ir),
        .in_code(w_code), .out_valid(w64_ov), .out_ready(w_ready),
        .out_data(w64_d), .out_err_corr(w64_c), .out_err_uncorr(w64_u),
        .out_syndrome(w64_s), .cnt_clr(w_clr), .cnt_corr(w64_cc), .cnt_uncorr(w64_cu));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {valid, data, corr, uncorr, syndrome}
    function automatic logic [79:0] pk(input logic v, input logic [63:0] d,
                                       input logic c, input logic u, input logic [7:0] s);
        return {5'b0, v, d, c, u, s};
    endfunction

    function automatic int rbits(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    function automatic logic [71:0] enc(input logic [63:0] d, input int dw);
        int r, cw, idx;
        logic [71:0] c;
        logic b;
        r = rbits(dw);
        cw = dw + r + 1;
        c = '0;
        idx = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[idx];
                idx++;
            end
        end
        for (int k = 0; k < r; k++) begin
            b = 1'b0;
            for (int p = 1; p < cw; p++)
                if (((p >> k) & 1) == 1 && p != (1 << k)) b = b ^ c[p-1];
            c[(1 << k) - 1] = b;
        end
        c[cw-1] = ^c;
        return c;
    endfunction

    function automatic logic [63:0] ext(input logic [71:0] c, input int dw);
        int cw, idx;
        logic [63:0] d;
        cw = dw + rbits(dw) + 1;
        d = '0;
        idx = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[idx] = c[p-1];
                idx++;
            end
        end
        return d;
    endfunction

    // One word through the 4-bit DUT; checks latency, outputs, then
    // completes the output handshake (optionally with cnt_clr on that edge).
    task automatic xfer4(input string tag, input logic [7:0] code, input logic [3:0] d,
                         input logic c, input logic u, input logic [2:0] s, input bit clr);
        int n;
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, 80'(n), 80'd1);
        chk(tag, pk(out_valid, 64'(out_data), out_err_corr, out_err_uncorr, 8'(out_syndrome)),
            pk(1'b1, 64'(d), c, u, 8'(s)));
        if (clr) cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
    endtask

    task automatic get_w(input int dw, output logic [79:0] o, output logic [31:0] cnt);
        case (dw)
            8:  begin o = pk(w8_ov, 64'(w8_d), w8_c, w8_u, 8'(w8_s));       cnt = {w8_cc, w8_cu};   end
            32: begin o = pk(w32_ov, 64'(w32_d), w32_c, w32_u, 8'(w32_s));  cnt = {w32_cc, w32_cu}; end
            default: begin o = pk(w64_ov, w64_d, w64_c, w64_u, 8'(w64_s)); cnt = {w64_cc, w64_cu}; end
        endcase
    endtask

    task automatic apply_w(input int dw, input logic [71:0] code, input logic [79:0] exp,
                           input string tag);
        logic [79:0] o;
        logic [31:0] cnt;
        int n;
        w_code  = code;
        w_valid = (dw == 8) ? 3'b001 : (dw == 32) ? 3'b010 : 3'b100;
        @(posedge clk);
        #1 w_valid = 3'b000;
        n = 0;
        @(negedge clk);
        get_w(dw, o, cnt);
        while (o[74] !== 1'b1 && n < 8) begin
            @(negedge clk);
            get_w(dw, o, cnt);
            n++;
        end
        chk(tag, o, exp);
    endtask

    task automatic sweep(input int dw);
        int r, cw, pi, pj, top;
        logic [63:0] d;
        logic [71:0] base, cd;
        logic [79:0] o;
        logic [31:0] cnt;
        r  = rbits(dw);
        cw = dw + r + 1;
        d  = 64'hA5C3_0F96_1E7B_48D2;
        if (dw < 64) d = d & ((64'd1 << dw) - 64'd1);
        base = enc(d, dw);
        apply_w(dw, base, pk(1'b1, d, 1'b0, 1'b0, 8'd0), $sformatf("w%0d.clean", dw));
        for (int i = 0; i < cw; i++) begin
            cd = base;
            cd[i] = ~cd[i];
            apply_w(dw, cd, pk(1'b1, d, 1'b1, 1'b0, (i == cw - 1) ? 8'd0 : 8'(i + 1)),
                    $sformatf("w%0d.single%0d", dw, i));
        end
        for (int i = 0; i < cw; i++) begin
            for (int j = i + 1; j < cw; j++) begin
                cd = base;
                cd[i] = ~cd[i];
                cd[j] = ~cd[j];
                pi = (i == cw - 1) ? 0 : i + 1;
                pj = (j == cw - 1) ? 0 : j + 1;
                apply_w(dw, cd, pk(1'b1, ext(cd, dw), 1'b0, 1'b1, 8'(pi ^ pj)),
                        $sformatf("w%0d.double%0d_%0d", dw, i, j));
            end
        end
        // three parity-position flips: odd parity, syndrome past the last position
        top = 1 << (r - 1);
        cd = base;
        cd[top-1]      = ~cd[top-1];
        cd[top/2-1]    = ~cd[top/2-1];
        cd[0]          = ~cd[0];
        apply_w(dw, cd, pk(1'b1, d, 1'b0, 1'b1, 8'(top + top / 2 + 1)),
                $sformatf("w%0d.phantom", dw));
        @(posedge clk);
        #1;
        get_w(dw, o, cnt);
        chk($sformatf("w%0d.cnt", dw), 80'(cnt),
            80'({16'(cw), 16'(cw * (cw - 1) / 2 + 1)}));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        w_valid = '0; w_code = '0; w_ready = 1'b1; w_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.out", pk(out_valid, 64'(out_data), out_err_corr, out_err_uncorr, 8'(out_syndrome)),
            pk(1'b0, 64'd0, 1'b0, 1'b0, 8'd0));
        chk("rst.in_ready", 80'(in_ready), 80'd1);
        chk("rst.cnt", 80'({cnt_corr, cnt_uncorr, s_cc, s_cu}), 80'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // legacy (8,4) vectors; 8'h55 is the codeword for 4'b1011, 8'hFF for 4'hF
        xfer4("clean55", 8'h55, 4'b1011, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("cnt.clean", 80'({cnt_corr, cnt_uncorr}), 80'({16'd0, 16'd0}));
        xfer4("pos5",    8'h45, 4'b1011, 1'b1, 1'b0, 3'd5, 1'b0);
        chk("cnt.pos5", 80'(cnt_corr), 80'd1);
        xfer4("ovp",     8'hD5, 4'b1011, 1'b1, 1'b0, 3'd0, 1'b0);
        xfer4("dbl12",   8'h56, 4'b1011, 1'b0, 1'b1, 3'd3, 1'b0);
        chk("cnt.dbl", 80'({cnt_corr, cnt_uncorr}), 80'({16'd2, 16'd1}));
        xfer4("cleanFF", 8'hFF, 4'hF,    1'b0, 1'b0, 3'd0, 1'b0);
        xfer4("ovpFF",   8'h7F, 4'hF,    1'b1, 1'b0, 3'd0, 1'b0);
        xfer4("pos7",    8'hBF, 4'hF,    1'b1, 1'b0, 3'd7, 1'b0);
        xfer4("pos3",    8'h51, 4'b1011, 1'b1, 1'b0, 3'd3, 1'b0);
        chk("cnt.main5", 80'(cnt_corr), 80'd5);
        chk("sat.corr3", 80'(s_cc), 80'd3);
        xfer4("clean00", 8'h00, 4'h0,    1'b0, 1'b0, 3'd0, 1'b0);
        xfer4("dbl12z",  8'h03, 4'h0,    1'b0, 1'b1, 3'd3, 1'b0);
        xfer4("dblovp",  8'h81, 4'h0,    1'b0, 1'b1, 3'd1, 1'b0);
        xfer4("dbl12b",  8'h56, 4'b1011, 1'b0, 1'b1, 3'd3, 1'b0);
        chk("cnt.unc4", 80'(cnt_uncorr), 80'd4);
        chk("sat.unc3", 80'(s_cu), 80'd3);

        // stall: three back-to-back words, consumer not ready for 5 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h45;
        @(posedge clk);
        #1 in_code = 8'h55;
        @(posedge clk);
        #1 in_code = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.in_ready", 80'(in_ready), 80'd0);
            chk("stall.hold", pk(out_valid, 64'(out_data), out_err_corr, out_err_uncorr,
                8'(out_syndrome)), pk(1'b1, 64'hB, 1'b1, 1'b0, 8'd5));
            chk("stall.cnt", 80'(cnt_corr), 80'd5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("stall.w2", pk(out_valid, 64'(out_data), out_err_corr, out_err_uncorr,
            8'(out_syndrome)), pk(1'b1, 64'hB, 1'b0, 1'b0, 8'd0));
        chk("stall.cnt1", 80'(cnt_corr), 80'd6);
        @(negedge clk);
        chk("stall.w3", pk(out_valid, 64'(out_data), out_err_corr, out_err_uncorr,
            8'(out_syndrome)), pk(1'b1, 64'hF, 1'b0, 1'b0, 8'd0));
        @(negedge clk);
        chk("stall.drain", 80'({out_valid, cnt_corr, cnt_uncorr}), 80'({1'b0, 16'd6, 16'd4}));
        @(posedge clk);
        #1;

        // clear on the same edge as a corrected handshake: clear wins
        xfer4("clrhit", 8'h45, 4'b1011, 1'b1, 1'b0, 3'd5, 1'b1);
        chk("clr.cnt", 80'({cnt_corr, cnt_uncorr, s_cc, s_cu}), 80'd0);

        // five single-error words: 2-bit counter sticks at 3
        xfer4("sat1", 8'h45, 4'b1011, 1'b1, 1'b0, 3'd5, 1'b0);
        xfer4("sat2", 8'hD5, 4'b1011, 1'b1, 1'b0, 3'd0, 1'b0);
        xfer4("sat3", 8'h7F, 4'hF,    1'b1, 1'b0, 3'd0, 1'b0);
        xfer4("sat4", 8'hBF, 4'hF,    1'b1, 1'b0, 3'd7, 1'b0);
        xfer4("sat5", 8'h51, 4'b1011, 1'b1, 1'b0, 3'd3, 1'b0);
        chk("sat.main", 80'(cnt_corr), 80'd5);
        chk("sat.cnt", 80'({s_cc, s_cu}), 80'({2'd3, 2'd0}));

        // reset with two words in flight
        in_valid = 1'b1;
        in_code  = 8'h55;
        @(posedge clk);
        #1 in_code = 8'h45;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid.pre", 80'(out_valid), 80'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.async", pk(out_valid, 64'(out_data), out_err_corr, out_err_uncorr,
            8'(out_syndrome)), pk(1'b0, 64'd0, 1'b0, 1'b0, 8'd0));
        chk("mid.ready_cnt", 80'({in_ready, cnt_corr, cnt_uncorr, s_cc, s_cu}), 80'({1'b1, 36'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid.nostale", 80'(out_valid), 80'd0);
        end
        @(posedge clk);
        #1;

        sweep(8);
        sweep(32);
        sweep(64);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
